nnrv_id: RTL and testbench



---
 rtl/nnrv_id_pkg.sv | 28 ++
 rtl/nnrv_id_if.sv | 22 ++
 rtl/nnrv_id_imm_gen.sv | 34 +++
 rtl/nnrv_id.sv | 154 +++++++++++++++
 tb/tb_nnrv_id.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nnrv_id_pkg.sv
// nnrv decode shared definitions: opcodes, branch funct3 codes, register-address width.
// Pure constants; no logic.
package nnrv_id_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/nnrv_id_if.sv
// Decode-to-execute bundle; master drives from the ID pipeline register, slave is execute.
// Registered by the producer; no backpressure (execute always accepts).
interface nnrv_id_ex_if import nnrv_id_pkg::*; #(
  parameter int XLEN = 64
);
  logic              valid;
  logic [XLEN-1:0]   pc;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [REG_AW-1:0] rd_addr;
  logic              rd_we;
  logic              illegal;

  modport master (output valid, pc, opcode, funct3, funct7b5, rs1_data, rs2_data,
                  imm, rd_addr, rd_we, illegal);
  modport slave  (input  valid, pc, opcode, funct3, funct7b5, rs1_data, rs2_data,
                  imm, rd_addr, rd_we, illegal);
endinterface

// File: rtl/nnrv_id_imm_gen.sv
// Combinational RV64I immediate generator; fmt_valid flags opcodes with a known format.
// Zero latency, no state.
module nnrv_imm_gen import nnrv_id_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic            o_fmt_valid
);

  always_comb begin
    o_imm       = '0;
    o_fmt_valid = 1'b1;
    case (i_instr[6:0])
      OPC_LUI, OPC_AUIPC:
        o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
      OPC_JAL:
        o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                 i_instr[20], i_instr[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32:
        o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:
        o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                 i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_OP, OPC_OP32:
        o_imm = '0;
      default:
        o_fmt_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/nnrv_id.sv
// nnrv RV64I decode: forwarding, load-use detection, same-cycle jump/branch redirect.
// Fetch controls are combinational; execute bundle is registered (1 cycle), no backpressure.
module nnrv_id import nnrv_id_pkg::*; #(
  parameter int XLEN        = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INSTR_WIDTH-1:0] i_if_instr,
  input  logic [XLEN-1:0]        i_if_cur_pc,
  output logic                   o_if_jmp_stall,
  output logic [XLEN-1:0]        o_if_jmp_pc,
  output logic                   o_if_hazard_stall,
  output logic [REG_AW-1:0]      o_rf_rs1_addr,
  output logic [REG_AW-1:0]      o_rf_rs2_addr,
  input  logic [XLEN-1:0]        i_rf_rs1_data,
  input  logic [XLEN-1:0]        i_rf_rs2_data,
  input  logic                   i_ex_rd_we,
  input  logic [REG_AW-1:0]      i_ex_rd_addr,
  input  logic [XLEN-1:0]        i_ex_rd_data,
  input  logic                   i_ex_is_load,
  input  logic                   i_wb_rd_we,
  input  logic [REG_AW-1:0]      i_wb_rd_addr,
  input  logic [XLEN-1:0]        i_wb_rd_data,
  nnrv_id_ex_if.master           ex
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]   w_imm, w_rs1_val, w_rs2_val, w_target, w_jalr_sum;
  logic              w_fmt_valid, w_legal, w_illegal, w_hazard, w_issue, w_redirect;
  logic              w_use_rs1, w_use_rs2, w_taken;
  logic              w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_br, w_is_st, w_is_op, w_is_op32;

  assign w_opcode = i_if_instr[6:0];
  assign w_funct3 = i_if_instr[14:12];
  assign w_rd     = i_if_instr[11:7];
  assign w_rs1    = i_if_instr[19:15];
  assign w_rs2    = i_if_instr[24:20];

  assign w_is_lui   = (w_opcode == OPC_LUI);
  assign w_is_auipc = (w_opcode == OPC_AUIPC);
  assign w_is_jal   = (w_opcode == OPC_JAL);
  assign w_is_jalr  = (w_opcode == OPC_JALR);
  assign w_is_br    = (w_opcode == OPC_BRANCH);
  assign w_is_st    = (w_opcode == OPC_STORE);
  assign w_is_op    = (w_opcode == OPC_OP);
  assign w_is_op32  = (w_opcode == OPC_OP32);

  nnrv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr     (i_if_instr[31:0]),
    .o_imm       (w_imm),
    .o_fmt_valid (w_fmt_valid)
  );

  // Opcode 0 has no format, so it is neither legal nor flagged illegal.
  assign w_legal   = w_fmt_valid && !(w_is_br && (w_funct3 == F3_RSV2 || w_funct3 == F3_RSV3));
  assign w_illegal = (w_opcode != 7'd0) && !w_legal;
  assign w_use_rs1 = w_legal && !(w_is_lui || w_is_auipc || w_is_jal);
  assign w_use_rs2 = w_legal && (w_is_br || w_is_st || w_is_op || w_is_op32);

  assign w_hazard = !i_rst && i_ex_is_load && i_ex_rd_we && (i_ex_rd_addr != '0) &&
                    ((w_use_rs1 && i_ex_rd_addr == w_rs1) || (w_use_rs2 && i_ex_rd_addr == w_rs2));

  // A load in EX never forwards; its data only exists once it reaches WB.
  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] rf,
                                          input logic ex_we, input logic [REG_AW-1:0] ex_a,
                                          input logic [XLEN-1:0] ex_d, input logic ex_ld,
                                          input logic wb_we, input logic [REG_AW-1:0] wb_a,
                                          input logic [XLEN-1:0] wb_d);
    if (a == '0)                           return '0;
    else if (ex_we && ex_a == a && !ex_ld) return ex_d;
    else if (wb_we && wb_a == a)           return wb_d;
    else                                   return rf;
  endfunction

  assign w_rs1_val = fwd(w_rs1, i_rf_rs1_data, i_ex_rd_we, i_ex_rd_addr, i_ex_rd_data,
                         i_ex_is_load, i_wb_rd_we, i_wb_rd_addr, i_wb_rd_data);
  assign w_rs2_val = fwd(w_rs2, i_rf_rs2_data, i_ex_rd_we, i_ex_rd_addr, i_ex_rd_data,
                         i_ex_is_load, i_wb_rd_we, i_wb_rd_addr, i_wb_rd_data);

  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      F3_BEQ:  w_taken = (w_rs1_val == w_rs2_val);
      F3_BNE:  w_taken = (w_rs1_val != w_rs2_val);
      F3_BLT:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      F3_BGE:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      F3_BLTU: w_taken = (w_rs1_val <  w_rs2_val);
      F3_BGEU: w_taken = (w_rs1_val >= w_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_rs1_val + w_imm;
  assign w_target   = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (i_if_cur_pc + w_imm);
  assign w_redirect = !i_rst && !w_hazard && w_legal && (w_is_jal || w_is_jalr || (w_is_br && w_taken));
  assign w_issue    = w_legal && !w_hazard;

  assign o_if_jmp_stall    = w_redirect;
  assign o_if_jmp_pc       = w_redirect ? w_target : '0;
  assign o_if_hazard_stall = w_hazard;
  assign o_rf_rs1_addr     = w_rs1;
  assign o_rf_rs2_addr     = w_rs2;

  logic              r_valid, r_funct7b5, r_rd_we, r_illegal;
  logic [XLEN-1:0]   r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic [REG_AW-1:0] r_rd_addr;

  // Bubbles and illegal ops carry an all-zero payload into execute.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
      r_pc       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd_addr  <= '0;
      r_rd_we    <= 1'b0;
    end else begin
      r_valid    <= w_issue;
      r_illegal  <= w_illegal && !w_hazard;
      r_pc       <= w_issue ? i_if_cur_pc : '0;
      r_opcode   <= w_issue ? w_opcode : '0;
      r_funct3   <= w_issue ? w_funct3 : '0;
      r_funct7b5 <= w_issue && i_if_instr[30];
      r_rs1_data <= w_issue ? w_rs1_val : '0;
      r_rs2_data <= w_issue ? w_rs2_val : '0;
      r_imm      <= w_issue ? w_imm : '0;
      r_rd_addr  <= w_issue ? w_rd : '0;
      r_rd_we    <= w_issue && (w_rd != '0) && !w_is_br && !w_is_st;
    end
  end

  assign ex.valid    = r_valid;
  assign ex.illegal  = r_illegal;
  assign ex.pc       = r_pc;
  assign ex.opcode   = r_opcode;
  assign ex.funct3   = r_funct3;
  assign ex.funct7b5 = r_funct7b5;
  assign ex.rs1_data = r_rs1_data;
  assign ex.rs2_data = r_rs2_data;
  assign ex.imm      = r_imm;
  assign ex.rd_addr  = r_rd_addr;
  assign ex.rd_we    = r_rd_we;

endmodule

// File: tb/tb_nnrv_id.sv
// Self-checking bench for nnrv_id: directed cases plus randomized decode against a field-level model.
module tb_nnrv_id;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_if_instr;
  logic [63:0] i_if_cur_pc;
  logic        o_if_jmp_stall, o_if_hazard_stall;
  logic [63:0] o_if_jmp_pc;
  logic [4:0]  o_rf_rs1_addr, o_rf_rs2_addr;
  logic [63:0] i_rf_rs1_data, i_rf_rs2_data;
  logic        i_ex_rd_we, i_ex_is_load, i_wb_rd_we;
  logic [4:0]  i_ex_rd_addr, i_wb_rd_addr;
  logic [63:0] i_ex_rd_data, i_wb_rd_data;

  nnrv_id_ex_if #(.XLEN(64)) ex_if ();

  nnrv_id #(.XLEN(64), .INSTR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_if_instr(i_if_instr), .i_if_cur_pc(i_if_cur_pc),
    .o_if_jmp_stall(o_if_jmp_stall), .o_if_jmp_pc(o_if_jmp_pc), .o_if_hazard_stall(o_if_hazard_stall),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .i_rf_rs1_data(i_rf_rs1_data), .i_rf_rs2_data(i_rf_rs2_data),
    .i_ex_rd_we(i_ex_rd_we), .i_ex_rd_addr(i_ex_rd_addr), .i_ex_rd_data(i_ex_rd_data),
    .i_ex_is_load(i_ex_is_load),
    .i_wb_rd_we(i_wb_rd_we), .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_data(i_wb_rd_data),
    .ex(ex_if)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model outputs: fetch controls (this cycle) and execute bundle (next cycle).
  logic        e_jmp, e_hz;
  logic [63:0] e_jpc;
  logic        n_valid, n_ill, n_we, n_f7;
  logic [63:0] n_pc, n_rs1, n_rs2, n_imm;
  logic [6:0]  n_opc;
  logic [2:0]  n_f3;
  logic [4:0]  n_rd;
  logic        o_jmp, o_hz;
  logic [63:0] o_jpc;

  function automatic logic [63:0] ref_fwd(input logic [4:0] a, input logic [63:0] rf);
    if (a == 0) return 64'd0;
    if (i_ex_rd_we && !i_ex_is_load && i_ex_rd_addr == a) return i_ex_rd_data;
    if (i_wb_rd_we && i_wb_rd_addr == a) return i_wb_rd_data;
    return rf;
  endfunction

  task automatic model();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  s1, s2, rd;
    logic        lui, auipc, jal, jalr, br, ld, st, opi, opr, opi32, opr32;
    logic        legal, use1, use2, taken, issue;
    longint      imm;
    logic [63:0] a, b, tgt;
    op = i_if_instr[6:0];  f3 = i_if_instr[14:12];
    rd = i_if_instr[11:7]; s1 = i_if_instr[19:15]; s2 = i_if_instr[24:20];
    lui = (op == 7'h37); auipc = (op == 7'h17); jal = (op == 7'h6F); jalr = (op == 7'h67);
    br = (op == 7'h63); ld = (op == 7'h03); st = (op == 7'h23); opi = (op == 7'h13);
    opr = (op == 7'h33); opi32 = (op == 7'h1B); opr32 = (op == 7'h3B);
    legal = lui | auipc | jal | jalr | ld | st | opi | opr | opi32 | opr32 |
            (br && f3 != 3'd2 && f3 != 3'd3);
    // Immediates as two's-complement values: top bit carries negative weight.
    imm = 0;
    if (lui || auipc)
      imm = longint'(i_if_instr[30:12]) * 4096 - (i_if_instr[31] ? 64'sd2147483648 : 64'sd0);
    else if (jal)
      imm = longint'(i_if_instr[19:12]) * 4096 + longint'(i_if_instr[20]) * 2048 +
            longint'(i_if_instr[30:21]) * 2 - (i_if_instr[31] ? 64'sd1048576 : 64'sd0);
    else if (jalr || ld || opi || opi32)
      imm = longint'(i_if_instr[30:20]) - (i_if_instr[31] ? 64'sd2048 : 64'sd0);
    else if (st)
      imm = longint'(i_if_instr[30:25]) * 32 + longint'(i_if_instr[11:7]) -
            (i_if_instr[31] ? 64'sd2048 : 64'sd0);
    else if (br)
      imm = longint'(i_if_instr[7]) * 2048 + longint'(i_if_instr[30:25]) * 32 +
            longint'(i_if_instr[11:8]) * 2 - (i_if_instr[31] ? 64'sd4096 : 64'sd0);
    use1 = legal && !(lui || auipc || jal);
    use2 = legal && (br || st || opr || opr32);
    e_hz = !i_rst && i_ex_is_load && i_ex_rd_we && i_ex_rd_addr != 0 &&
           ((use1 && i_ex_rd_addr == s1) || (use2 && i_ex_rd_addr == s2));
    a = ref_fwd(s1, i_rf_rs1_data);
    b = ref_fwd(s2, i_rf_rs2_data);
    case (f3)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = ($signed(a) <  $signed(b));
      3'd5: taken = ($signed(a) >= $signed(b));
      3'd6: taken = (a <  b);
      3'd7: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    tgt = jalr ? ((a + 64'(imm)) & ~64'd1) : (i_if_cur_pc + 64'(imm));
    e_jmp = !i_rst && !e_hz && legal && (jal || jalr || (br && taken));
    e_jpc = e_jmp ? tgt : 64'd0;
    issue = !i_rst && legal && !e_hz;
    n_valid = issue;
    n_ill = !i_rst && op != 0 && !legal;
    n_pc = i_if_cur_pc; n_opc = op; n_f3 = f3; n_f7 = i_if_instr[30];
    n_rs1 = a; n_rs2 = b; n_imm = 64'(imm); n_rd = rd;
    n_we = issue && rd != 0 && !br && !st;
  endtask

  // Inputs are set at the falling edge; fetch controls are checked before the rising edge,
  // the execute bundle just after it.
  task automatic step(input string tag);
    #1;
    model();
    o_jmp = o_if_jmp_stall; o_jpc = o_if_jmp_pc; o_hz = o_if_hazard_stall;
    chk({tag, ".jmp_stall"}, o_jmp, e_jmp);
    chk({tag, ".jmp_pc"}, o_jpc, e_jpc);
    chk({tag, ".hazard"}, o_hz, e_hz);
    chk({tag, ".rs1_addr"}, o_rf_rs1_addr, i_if_instr[19:15]);
    chk({tag, ".rs2_addr"}, o_rf_rs2_addr, i_if_instr[24:20]);
    @(posedge i_clk);
    #1;
    chk({tag, ".valid"}, ex_if.valid, n_valid);
    chk({tag, ".illegal"}, ex_if.illegal, n_ill);
    chk({tag, ".rd_we"}, ex_if.rd_we, n_we);
    if (n_valid) begin
      chk({tag, ".pc"}, ex_if.pc, n_pc);
      chk({tag, ".opcode"}, ex_if.opcode, n_opc);
      chk({tag, ".funct3"}, ex_if.funct3, n_f3);
      chk({tag, ".funct7b5"}, ex_if.funct7b5, n_f7);
      chk({tag, ".rs1_data"}, ex_if.rs1_data, n_rs1);
      chk({tag, ".rs2_data"}, ex_if.rs2_data, n_rs2);
      chk({tag, ".imm"}, ex_if.imm, n_imm);
      chk({tag, ".rd_addr"}, ex_if.rd_addr, n_rd);
    end
  endtask

  task automatic idle_inputs();
    i_if_instr = 32'd0; i_if_cur_pc = 64'd0;
    i_rf_rs1_data = 64'd0; i_rf_rs2_data = 64'd0;
    i_ex_rd_we = 1'b0; i_ex_rd_addr = 5'd0; i_ex_rd_data = 64'd0; i_ex_is_load = 1'b0;
    i_wb_rd_we = 1'b0; i_wb_rd_addr = 5'd0; i_wb_rd_data = 64'd0;
  endtask

  logic [6:0] opc_tab [14];

  initial begin
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                7'h13, 7'h33, 7'h1B, 7'h3B, 7'h00, 7'h7F, 7'h0F};
    idle_inputs();
    i_rst = 1'b1;
    i_if_instr = 32'h0050_0093;

    @(negedge i_clk); step("rst0");
    @(negedge i_clk); step("rst1");
    chk("rst.ex_all", {ex_if.valid, ex_if.illegal, ex_if.rd_we, ex_if.funct7b5, ex_if.rd_addr,
                       ex_if.opcode, ex_if.funct3}, 64'd0);
    chk("rst.ex_pc_imm", ex_if.pc | ex_if.imm | ex_if.rs1_data | ex_if.rs2_data, 64'd0);
    chk("rst.hz_jmp", {o_hz, o_jmp}, 64'd0);

    @(negedge i_clk); i_rst = 1'b0; i_if_instr = 32'd0; step("bubble");
    chk("bubble.valid", ex_if.valid, 1'b0);

    @(negedge i_clk); i_if_instr = 32'h0050_0093; i_if_cur_pc = 64'h100; step("addi");
    chk("addi.tp", {ex_if.valid, ex_if.rd_we, ex_if.rd_addr, ex_if.pc[15:0], ex_if.imm[15:0]},
        {1'b1, 1'b1, 5'd1, 16'h0100, 16'h0005});

    @(negedge i_clk); i_if_instr = 32'h0100_00EF; i_if_cur_pc = 64'h200; step("jal");
    chk("jal.tp_pc", o_jpc, 64'h210);
    chk("jal.tp_ex", {ex_if.valid, ex_if.rd_addr}, {1'b1, 5'd1});

    @(negedge i_clk);
    i_if_instr = 32'hFE20_8CE3; i_if_cur_pc = 64'h300;
    i_ex_rd_we = 1'b1; i_ex_rd_addr = 5'd1; i_ex_rd_data = 64'd7; i_rf_rs2_data = 64'd7;
    step("beq_t");
    chk("beq_t.tp", {o_jmp, o_jpc}, {1'b1, 64'h2F8});
    @(negedge i_clk); i_rf_rs2_data = 64'd8; step("beq_nt");
    chk("beq_nt.tp", o_jmp, 1'b0);

    @(negedge i_clk);
    idle_inputs();
    i_if_instr = 32'h0002_8333; i_if_cur_pc = 64'h400;
    i_ex_rd_we = 1'b1; i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5; i_rf_rs1_data = 64'h99;
    step("lu_stall");
    chk("lu_stall.tp", {o_hz, ex_if.valid}, {1'b1, 1'b0});
    @(negedge i_clk);
    i_ex_rd_we = 1'b0; i_ex_is_load = 1'b0; i_ex_rd_addr = 5'd0;
    i_wb_rd_we = 1'b1; i_wb_rd_addr = 5'd5; i_wb_rd_data = 64'h55;
    step("lu_go");
    chk("lu_go.tp", {ex_if.valid, ex_if.rs1_data}, {1'b1, 64'h55});

    @(negedge i_clk);
    idle_inputs();
    i_if_instr = 32'h0002_9463; i_if_cur_pc = 64'h500; i_rf_rs1_data = 64'h1;
    i_ex_rd_we = 1'b1; i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5;
    step("lu_bne");
    chk("lu_bne.tp", {o_hz, o_jmp}, {1'b1, 1'b0});

    @(negedge i_clk); idle_inputs(); i_if_instr = 32'h0000_007F; step("ill_opc");
    chk("ill_opc.tp", {ex_if.illegal, ex_if.valid, o_jmp}, {1'b1, 1'b0, 1'b0});
    @(negedge i_clk); i_if_instr = 32'h0000_2063; step("ill_br");
    chk("ill_br.tp", {ex_if.illegal, ex_if.valid, o_jmp}, {1'b1, 1'b0, 1'b0});
    @(negedge i_clk); i_if_instr = 32'h0050_0093; step("ill_clr");
    chk("ill_clr.tp", {ex_if.illegal, ex_if.valid}, {1'b0, 1'b1});

    @(negedge i_clk);
    i_if_instr = 32'h0002_8333; i_ex_rd_we = 1'b1; i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5;
    i_rst = 1'b1;
    step("rst_stall");
    chk("rst_stall.tp", {o_hz, ex_if.valid, ex_if.rd_we, ex_if.rd_addr}, 64'd0);
    @(negedge i_clk); i_rst = 1'b0; idle_inputs(); step("post_rst");

    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      i_rst = ($urandom_range(0, 31) == 0);
      i_if_instr = $urandom;
      i_if_instr[6:0] = opc_tab[$urandom_range(0, 13)];
      if ($urandom_range(0, 3) != 0) begin
        i_if_instr[19:15] = 5'($urandom_range(0, 3));
        i_if_instr[24:20] = 5'($urandom_range(0, 3));
      end
      i_if_cur_pc = {$urandom, $urandom};
      i_rf_rs1_data = {$urandom, $urandom};
      i_rf_rs2_data = ($urandom_range(0, 2) == 0) ? i_rf_rs1_data : {$urandom, $urandom};
      i_ex_rd_we = $urandom_range(0, 1) == 1;
      i_ex_is_load = $urandom_range(0, 2) == 0;
      i_ex_rd_addr = 5'($urandom_range(0, 3));
      i_ex_rd_data = ($urandom_range(0, 2) == 0) ? i_rf_rs2_data : {$urandom, $urandom};
      i_wb_rd_we = $urandom_range(0, 1) == 1;
      i_wb_rd_addr = 5'($urandom_range(0, 3));
      i_wb_rd_data = {$urandom, $urandom};
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
